// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit-type codes carried in the top bits of every
// flit, and the state encoding of the packet injector FSM. The router-side
// flit identifier decodes the same type codes.
package noc_pkg;

  // Flit-type codes. Code 2'b00 is reserved and never sent.
  localparam logic [1:0] FLIT_HEAD = 2'b01;
  localparam logic [1:0] FLIT_BODY = 2'b10;
  localparam logic [1:0] FLIT_TAIL = 2'b11;

  // Injector FSM states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BODY  = 2'd1,
    TAIL  = 2'd2,
    DRAIN = 2'd3
  } inj_state_t;

endpackage

// File: rtl/flit_out_reg.sv
// Single-entry valid/ready output register. Holds one flit towards the
// router port. A new flit may be loaded in the same cycle the current one
// transfers, giving one flit per cycle of throughput. While the flit is
// valid and not accepted, the data is held stable.
module flit_out_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,        // asynchronous, active-low
  input  logic             load,       // load load_data this cycle
  input  logic [WIDTH-1:0] load_data,
  input  logic             ready,      // downstream ready_in
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic             can_load    // register empty or transferring
);

  logic             valid_q;
  logic             valid_d;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;
  logic             load_ok;

  assign can_load = !valid_q || ready;
  // A load while the register is blocked would drop a flit; refuse it.
  assign load_ok  = load && can_load;

  // Next-state: a load wins, otherwise a transfer empties the register.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load_ok) begin
      valid_d = 1'b1;
      data_d  = load_data;
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end
  end

  // Output flops, cleared immediately on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;

endmodule

// File: rtl/packet_injector.sv
// Packet injector: transmit end of a router input-port link. Takes a packet
// request (destination) and a stream of payload words and emits one packet
// of FlitPerPacket flits (HEAD, BODY..., TAIL) through a registered
// valid/ready output. valid_out never depends on ready_out.
module packet_injector
  import noc_pkg::*;
#(
  parameter int   N             = 4,
  parameter int   INDEX         = 1,
  parameter int   DATA_WIDTH    = 8,
  parameter int   TYPE_WIDTH    = 2,
  parameter int   FlitPerPacket = 6,
  parameter int   SEQ_WIDTH     = 2,
  localparam int  DEST_WIDTH    = $clog2(N),
  localparam int  PLD_WIDTH     = DATA_WIDTH - TYPE_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,        // asynchronous, active-low
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [DEST_WIDTH-1:0] req_dest,
  input  logic                  pld_valid,
  output logic                  pld_ready,
  input  logic [PLD_WIDTH-1:0]  pld_data,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  input  logic                  ready_out,
  output logic                  busy,
  output logic [15:0]           pkts_sent
);

  localparam int CNT_WIDTH = $clog2(FlitPerPacket + 1);
  localparam int HDR_WIDTH = SEQ_WIDTH + 2 * DEST_WIDTH;
  localparam logic [DEST_WIDTH-1:0] SRC_ID    = DEST_WIDTH'(INDEX);
  localparam logic [CNT_WIDTH-1:0]  LAST_BODY = CNT_WIDTH'(FlitPerPacket - 1);

  // FSM and bookkeeping state
  inj_state_t           state_q;
  inj_state_t           state_d;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_d;
  logic [SEQ_WIDTH-1:0] seq_q;
  logic [SEQ_WIDTH-1:0] seq_d;
  logic [15:0]          pkts_q;
  logic [15:0]          pkts_d;
  // Low until the first clock edge after reset so no request is accepted
  // while reset is asserted.
  logic                 live_q;
  logic                 live_d;

  // Output register interface
  logic                  can_load;
  logic                  load;
  logic [DATA_WIDTH-1:0] load_data;

  // Handshake terms
  logic req_fire;
  logic pld_fire;
  logic tail_xfer;
  logic [CNT_WIDTH-1:0] cnt_inc;

  // Head payload: {seq, src, dest}, LSB aligned. If it is wider than the
  // payload field the top bits go first, which drops seq bits first.
  logic [HDR_WIDTH-1:0] hdr_fields;
  logic [PLD_WIDTH-1:0] head_low;

  assign hdr_fields = {seq_q, SRC_ID, req_dest};

  generate
    if (HDR_WIDTH >= PLD_WIDTH) begin : g_hdr_trunc
      assign head_low = hdr_fields[PLD_WIDTH-1:0];
    end else begin : g_hdr_pad
      assign head_low = {{(PLD_WIDTH - HDR_WIDTH){1'b0}}, hdr_fields};
    end
  endgenerate

  // Ready outputs depend only on the state and the register's can-load term.
  assign req_ready = live_q && (state_q == IDLE) && can_load;
  assign pld_ready = ((state_q == BODY) || (state_q == TAIL)) && can_load;

  assign req_fire  = req_valid && req_ready;
  assign pld_fire  = pld_valid && pld_ready;
  assign tail_xfer = valid_out && ready_out;
  assign cnt_inc   = cnt_q + CNT_WIDTH'(1);

  // FSM next-state, flit assembly and counters.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    seq_d     = seq_q;
    pkts_d    = pkts_q;
    live_d    = 1'b1;
    load      = 1'b0;
    load_data = '0;
    case (state_q)
      IDLE: begin
        if (req_fire) begin
          load      = 1'b1;
          load_data = {TYPE_WIDTH'(FLIT_HEAD), head_low};
          cnt_d     = CNT_WIDTH'(1);
          state_d   = (FlitPerPacket > 2) ? BODY : TAIL;
        end
      end
      BODY: begin
        if (pld_fire) begin
          load      = 1'b1;
          load_data = {TYPE_WIDTH'(FLIT_BODY), pld_data};
          cnt_d     = cnt_inc;
          if (cnt_inc == LAST_BODY) begin
            state_d = TAIL;
          end
        end
      end
      TAIL: begin
        if (pld_fire) begin
          load      = 1'b1;
          load_data = {TYPE_WIDTH'(FLIT_TAIL), pld_data};
          cnt_d     = cnt_inc;
          state_d   = DRAIN;
        end
      end
      DRAIN: begin
        // In DRAIN the only flit in the register is the TAIL.
        if (tail_xfer) begin
          pkts_d  = pkts_q + 16'd1;
          seq_d   = seq_q + SEQ_WIDTH'(1);
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State flops; reset abandons any packet in flight immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      seq_q   <= '0;
      pkts_q  <= '0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      seq_q   <= seq_d;
      pkts_q  <= pkts_d;
      live_q  <= live_d;
    end
  end

  flit_out_reg #(
    .WIDTH (DATA_WIDTH)
  ) u_out_reg (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_data (load_data),
    .ready     (ready_out),
    .valid     (valid_out),
    .data      (data_out),
    .can_load  (can_load)
  );

  assign busy      = (state_q != IDLE);
  assign pkts_sent = pkts_q;

endmodule

// File: tb/tb_packet_injector.sv
// Testbench for packet_injector: drives random requests/payload words and
// compares the transferred flit stream against a packet-level model.
module tb_packet_injector;

  localparam int FPP  = 6;
  localparam int SRC  = 1;
  localparam int SRC2 = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [1:0]  req_dest;
  logic        pld_valid, pld_ready;
  logic [5:0]  pld_data;
  logic [7:0]  data_out;
  logic        valid_out, ready_out;
  logic        busy;
  logic [15:0] pkts_sent;

  logic        r2_valid, r2_ready;
  logic [1:0]  r2_dest;
  logic        p2_valid, p2_ready;
  logic [5:0]  p2_data;
  logic [7:0]  d2_out;
  logic        v2_out, ready2;
  logic        busy2;
  logic [15:0] pkts2;

  always #5 clk = ~clk;

  packet_injector #(.N(4), .INDEX(SRC), .DATA_WIDTH(8), .TYPE_WIDTH(2),
                    .FlitPerPacket(FPP), .SEQ_WIDTH(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_dest(req_dest), .pld_valid(pld_valid), .pld_ready(pld_ready),
    .pld_data(pld_data), .data_out(data_out), .valid_out(valid_out),
    .ready_out(ready_out), .busy(busy), .pkts_sent(pkts_sent));

  packet_injector #(.N(4), .INDEX(SRC2), .DATA_WIDTH(8), .TYPE_WIDTH(2),
                    .FlitPerPacket(2), .SEQ_WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .req_valid(r2_valid), .req_ready(r2_ready),
    .req_dest(r2_dest), .pld_valid(p2_valid), .pld_ready(p2_ready),
    .pld_data(p2_data), .data_out(d2_out), .valid_out(v2_out),
    .ready_out(ready2), .busy(busy2), .pkts_sent(pkts2));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int req_cyc = 0;
  bit timed_out;
  bit rand_mode, req_en, pld_en;

  logic [7:0] obs_q[$];
  int         obs_cyc_q[$];
  logic [7:0] exp_q[$];
  logic [1:0] req_q[$];
  logic [5:0] pld_q[$];
  logic [5:0] mw_q[$];
  int         model_seq = 0;
  int         exp_pkts = 0;

  // Packet-level model: one HEAD from {seq,src,dest}, FPP-2 BODY, one TAIL.
  function automatic void model_packet(input logic [1:0] dest);
    logic [5:0] w;
    exp_q.push_back({2'b01, 6'((model_seq % 4) * 16 + SRC * 4 + int'(dest))});
    for (int i = 1; i < FPP; i++) begin
      w = mw_q.pop_front();
      exp_q.push_back({(i == FPP - 1) ? 2'b11 : 2'b10, w});
    end
    model_seq = (model_seq + 1) % 4;
    exp_pkts++;
  endfunction

  task automatic drive_inputs();
    if (rand_mode) begin
      ready_out = ($urandom_range(0, 3) != 0);
      pld_en    = ($urandom_range(0, 4) != 0);
    end
    req_valid = req_en && (req_q.size() > 0);
    req_dest  = req_valid ? req_q[0] : 2'd0;
    pld_valid = pld_en && (pld_q.size() > 0);
    pld_data  = pld_valid ? pld_q[0] : 6'd0;
  endtask

  // One clock cycle: sample handshakes mid-cycle, then advance to the next negedge.
  task automatic tick();
    logic [1:0] dd;
    logic [5:0] dw;
    #1;
    if (rst && valid_out && ready_out) begin
      obs_q.push_back(data_out);
      obs_cyc_q.push_back(cyc);
    end
    if (rst && req_valid && req_ready) begin
      req_cyc = cyc;
      dd = req_q.pop_front();
    end
    if (rst && pld_valid && pld_ready) dw = pld_q.pop_front();
    @(negedge clk);
    cyc++;
    drive_inputs();
  endtask

  task automatic run_until(input int n, input int budget);
    int c;
    timed_out = 1'b0;
    c = 0;
    while (obs_q.size() < n && c < budget) begin
      tick();
      c++;
    end
    if (obs_q.size() < n) timed_out = 1'b1;
  endtask

  task automatic clear_all();
    obs_q.delete(); obs_cyc_q.delete(); exp_q.delete();
    req_q.delete(); pld_q.delete(); mw_q.delete();
    model_seq = 0; exp_pkts = 0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    rand_mode = 1'b0; req_en = 1'b1; pld_en = 1'b1; ready_out = 1'b1;
    clear_all();
    drive_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    cyc = 0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    rand_mode = 1'b0; req_en = 1'b1; pld_en = 1'b1; ready_out = 1'b1;
    clear_all();
    drive_inputs();
    repeat (2) @(negedge clk);
    #1;
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid_out got=%b want=0", valid_out); end
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data_out got=%h want=00", data_out); end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready got=%b want=0", req_ready); end
    checks++; if (pld_ready !== 1'b0) begin errors++; $display("FAIL reset_pld_ready got=%b want=0", pld_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (pkts_sent !== 16'd0) begin errors++; $display("FAIL reset_pkts got=%0d want=0", pkts_sent); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL idle_req_ready got=%b want=1", req_ready); end
    $display("test_reset done");
  endtask

  task automatic test_basic();
    do_reset();
    req_q.push_back(2'd2);
    for (int i = 1; i <= 5; i++) begin
      pld_q.push_back(6'(i));
      mw_q.push_back(6'(i));
    end
    model_packet(2'd2);
    drive_inputs();
    run_until(FPP, 50);
    repeat (2) tick();
    checks++; if (timed_out) begin errors++; $display("FAIL basic_timeout got=%0d flits want=%0d", obs_q.size(), FPP); end
    checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL basic_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL basic_flit%0d got=%h want=%h", i, obs_q[i], exp_q[i]); end
    end
    if (obs_q.size() > 0) begin
      checks++;
      if (obs_q[0] !== 8'h46) begin errors++; $display("FAIL basic_head got=%h want=46", obs_q[0]); end
      checks++;
      if (obs_cyc_q[0] !== req_cyc + 1) begin errors++; $display("FAIL basic_head_latency got=%0d want=%0d", obs_cyc_q[0], req_cyc + 1); end
    end
    for (int i = 1; i < obs_cyc_q.size(); i++) begin
      checks++;
      if (obs_cyc_q[i] !== obs_cyc_q[0] + i) begin errors++; $display("FAIL basic_consecutive%0d got=%0d want=%0d", i, obs_cyc_q[i], obs_cyc_q[0] + i); end
    end
    checks++; if (pkts_sent !== 16'(exp_pkts)) begin errors++; $display("FAIL basic_pkts got=%0d want=%0d", pkts_sent, exp_pkts); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy got=%b want=0", busy); end
    $display("test_basic: %0d flits observed", obs_q.size());
  endtask

  task automatic test_backpressure();
    bit found;
    logic [1:0] d;
    logic [5:0] w;
    do_reset();
    d = 2'($urandom);
    req_q.push_back(d);
    for (int i = 0; i < FPP - 1; i++) begin
      w = 6'($urandom);
      pld_q.push_back(w);
      mw_q.push_back(w);
    end
    model_packet(d);
    drive_inputs();
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      #1;
      if (valid_out && obs_q.size() == 3) found = 1'b1;
      else tick();
    end
    checks++; if (!found) begin errors++; $display("FAIL bp_body3_timeout got=%0d flits want=3", obs_q.size()); end
    ready_out = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (data_out !== exp_q[3]) begin errors++; $display("FAIL bp_hold%0d got=%h want=%h", k, data_out, exp_q[3]); end
      checks++; if (pld_ready !== 1'b0) begin errors++; $display("FAIL bp_pld_ready%0d got=%b want=0", k, pld_ready); end
      checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL bp_valid%0d got=%b want=1", k, valid_out); end
      tick();
    end
    ready_out = 1'b1;
    run_until(FPP, 50);
    repeat (2) tick();
    checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL bp_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL bp_flit%0d got=%h want=%h", i, obs_q[i], exp_q[i]); end
    end
    $display("test_backpressure: dest=%0d flits=%0d", d, obs_q.size());
  endtask

  task automatic test_starvation();
    logic [1:0] d;
    logic [5:0] w;
    logic [5:0] words[FPP-1];
    do_reset();
    d = 2'($urandom);
    req_q.push_back(d);
    for (int i = 0; i < FPP - 1; i++) begin
      w = 6'($urandom);
      words[i] = w;
      mw_q.push_back(w);
    end
    pld_q.push_back(words[0]);
    pld_q.push_back(words[1]);
    model_packet(d);
    drive_inputs();
    run_until(3, 40);
    checks++; if (timed_out) begin errors++; $display("FAIL starve_first_bodies got=%0d flits want=3", obs_q.size()); end
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL starve_valid%0d got=%b want=0", k, valid_out); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL starve_busy%0d got=%b want=1", k, busy); end
      tick();
    end
    for (int i = 2; i < FPP - 1; i++) pld_q.push_back(words[i]);
    drive_inputs();
    run_until(FPP, 50);
    repeat (2) tick();
    checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL starve_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL starve_flit%0d got=%h want=%h", i, obs_q[i], exp_q[i]); end
    end
    checks++; if (pkts_sent !== 16'(exp_pkts)) begin errors++; $display("FAIL starve_pkts got=%0d want=%0d", pkts_sent, exp_pkts); end
    $display("test_starvation: dest=%0d flits=%0d", d, obs_q.size());
  endtask

  task automatic test_back_to_back();
    logic [1:0] d;
    logic [5:0] w;
    do_reset();
    for (int p = 0; p < 5; p++) begin
      d = 2'($urandom);
      req_q.push_back(d);
      for (int i = 0; i < FPP - 1; i++) begin
        w = 6'($urandom);
        pld_q.push_back(w);
        mw_q.push_back(w);
      end
      model_packet(d);
    end
    rand_mode = 1'b1;
    drive_inputs();
    run_until(5 * FPP, 2000);
    rand_mode = 1'b0;
    ready_out = 1'b1;
    pld_en = 1'b1;
    drive_inputs();
    repeat (3) tick();
    checks++; if (timed_out) begin errors++; $display("FAIL b2b_timeout got=%0d flits want=%0d", obs_q.size(), 5 * FPP); end
    checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL b2b_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_flit%0d got=%h want=%h", i, obs_q[i], exp_q[i]); end
    end
    if (obs_q.size() >= 5 * FPP) begin
      checks++;
      if (obs_q[FPP][5:4] !== 2'd1) begin errors++; $display("FAIL b2b_seq2 got=%0d want=1", obs_q[FPP][5:4]); end
      checks++;
      if (obs_q[4 * FPP][5:4] !== 2'd0) begin errors++; $display("FAIL b2b_seq_wrap got=%0d want=0", obs_q[4 * FPP][5:4]); end
    end
    checks++; if (pkts_sent !== 16'(exp_pkts)) begin errors++; $display("FAIL b2b_pkts got=%0d want=%0d", pkts_sent, exp_pkts); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy got=%b want=0", busy); end
    $display("test_back_to_back: %0d flits, %0d packets", obs_q.size(), pkts_sent);
  endtask

  task automatic test_async_reset();
    bit found;
    logic [1:0] d;
    logic [5:0] w;
    do_reset();
    req_q.push_back(2'd1);
    for (int i = 0; i < FPP - 1; i++) pld_q.push_back(6'($urandom));
    drive_inputs();
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      #1;
      if (valid_out && obs_q.size() >= 2) found = 1'b1;
      else tick();
    end
    checks++; if (!found) begin errors++; $display("FAIL areset_body_timeout got=%0d flits want=2", obs_q.size()); end
    #2;
    rst = 1'b0;
    #1;
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL areset_valid got=%b want=0", valid_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL areset_busy got=%b want=0", busy); end
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL areset_data got=%h want=00", data_out); end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL areset_req_ready got=%b want=0", req_ready); end
    clear_all();
    drive_inputs();
    @(negedge clk);
    rst = 1'b1;
    d = 2'($urandom);
    req_q.push_back(d);
    for (int i = 0; i < FPP - 1; i++) begin
      w = 6'($urandom);
      pld_q.push_back(w);
      mw_q.push_back(w);
    end
    model_packet(d);
    drive_inputs();
    run_until(FPP, 50);
    repeat (2) tick();
    checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL areset_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL areset_flit%0d got=%h want=%h", i, obs_q[i], exp_q[i]); end
    end
    checks++; if (pkts_sent !== 16'd1) begin errors++; $display("FAIL areset_pkts got=%0d want=1", pkts_sent); end
    $display("test_async_reset: dest=%0d flits=%0d", d, obs_q.size());
  endtask

  task automatic test_fpp2();
    logic [7:0] got[$];
    logic [1:0] d;
    logic [5:0] w;
    bit hs_r, hs_p, tail_seen;
    do_reset();
    d = 2'($urandom);
    w = 6'($urandom);
    r2_valid = 1'b1; r2_dest = d; p2_valid = 1'b1; p2_data = w; ready2 = 1'b1;
    hs_r = 1'b0; hs_p = 1'b0;
    for (int c = 0; c < 20; c++) begin
      #1;
      tail_seen = 1'b0;
      if (v2_out && ready2) begin
        got.push_back(d2_out);
        if (d2_out[7:6] == 2'b11) begin
          tail_seen = 1'b1;
          checks++;
          if (pkts2 !== 16'd0) begin errors++; $display("FAIL fpp2_pkts_before got=%0d want=0", pkts2); end
        end
      end
      if (r2_valid && r2_ready) hs_r = 1'b1;
      if (p2_valid && p2_ready) hs_p = 1'b1;
      @(negedge clk);
      if (hs_r) r2_valid = 1'b0;
      if (hs_p) p2_valid = 1'b0;
      if (tail_seen) begin
        #1;
        checks++;
        if (pkts2 !== 16'd1) begin errors++; $display("FAIL fpp2_pkts_after got=%0d want=1", pkts2); end
      end
    end
    checks++; if (got.size() !== 2) begin errors++; $display("FAIL fpp2_count got=%0d want=2", got.size()); end
    if (got.size() >= 2) begin
      checks++;
      if (got[0] !== {2'b01, 6'(SRC2 * 4 + int'(d))}) begin errors++; $display("FAIL fpp2_head got=%h want=%h", got[0], {2'b01, 6'(SRC2 * 4 + int'(d))}); end
      checks++;
      if (got[1] !== {2'b11, w}) begin errors++; $display("FAIL fpp2_tail got=%h want=%h", got[1], {2'b11, w}); end
    end
    checks++; if (busy2 !== 1'b0) begin errors++; $display("FAIL fpp2_busy got=%b want=0", busy2); end
    $display("test_fpp2: dest=%0d flits=%0d pkts=%0d", d, got.size(), pkts2);
  endtask

  initial begin
    rst = 1'b0;
    req_valid = 1'b0; req_dest = 2'd0; pld_valid = 1'b0; pld_data = 6'd0; ready_out = 1'b1;
    r2_valid = 1'b0; r2_dest = 2'd0; p2_valid = 1'b0; p2_data = 6'd0; ready2 = 1'b1;
    rand_mode = 1'b0; req_en = 1'b1; pld_en = 1'b1;
    test_reset();
    test_basic();
    test_backpressure();
    test_starvation();
    test_back_to_back();
    test_async_reset();
    test_fpp2();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
